// File: rtl/irq_gateway.sv
// Interrupt gateway: per-source level/edge capture with a claim/complete handshake toward the PLIC.
// Optional `IRQ_GATEWAY_SYNC_EN` adds a 2-flop input synchroniser (+2 cycles latency).
module irq_gateway #(
  parameter int                NumSrc     = 32,
  parameter logic [NumSrc-1:0] EdgeMask   = '0,
  parameter int                CountWidth = 4,
  parameter int                IdWidth    = $clog2(NumSrc)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NumSrc-1:0]  irq_i,
  input  logic               claim_valid_i,
  input  logic [IdWidth-1:0] claim_id_i,
  input  logic               complete_valid_i,
  input  logic [IdWidth-1:0] complete_id_i,
  output logic [NumSrc-1:0]  pending_o,
  output logic [NumSrc-1:0]  inflight_o
);

  // One bit per visible state, so both outputs come straight from flops.
  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] PENDING  = 2'b01;
  localparam logic [1:0] INFLIGHT = 2'b10;

  logic [NumSrc-1:0] irq_s;

`ifdef IRQ_GATEWAY_SYNC_EN
  logic [NumSrc-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_i;
`endif

  logic unused_irq0;
  assign unused_irq0 = irq_s[0];

  assign pending_o[0]  = 1'b0;
  assign inflight_o[0] = 1'b0;

  for (genvar i = 1; i < NumSrc; i++) begin : g_src
    logic [1:0] st_q, st_d;
    logic       req;
    logic       claim_hit, compl_hit;

    // IDs 0 and >= NumSrc can never equal i, so they fall through as no-ops.
    assign claim_hit = claim_valid_i && (claim_id_i == IdWidth'(i));
    assign compl_hit = complete_valid_i && (complete_id_i == IdWidth'(i));

    if (EdgeMask[i]) begin : g_edge
      logic                  prev_q;
      logic                  edge_det;
      logic [CountWidth-1:0] cnt_q, cnt_d;

      assign edge_det = irq_s[i] & ~prev_q;
      assign req      = edge_det | (cnt_q != '0);

      // A request taken from IDLE consumes one edge; a fresh edge in that same cycle replaces it.
      always_comb begin
        cnt_d = cnt_q;
        if (st_q == IDLE && req) begin
          if (!edge_det) cnt_d = cnt_q - CountWidth'(1);
        end else if (edge_det && cnt_q != '1) begin
          cnt_d = cnt_q + CountWidth'(1);
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          prev_q <= 1'b0;
          cnt_q  <= '0;
        end else begin
          prev_q <= irq_s[i];
          cnt_q  <= cnt_d;
        end
      end
    end else begin : g_level
      assign req = irq_s[i];
    end

    always_comb begin
      st_d = st_q;
      case (st_q)
        IDLE:     if (req)       st_d = PENDING;
        PENDING:  if (claim_hit) st_d = INFLIGHT;
        INFLIGHT: if (compl_hit) st_d = IDLE;
        default:                 st_d = IDLE;
      endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) st_q <= IDLE;
      else         st_q <= st_d;
    end

    assign pending_o[i]  = st_q[0];
    assign inflight_o[i] = st_q[1];
  end

endmodule
